// File: rtl/fetch_prefetch_q.sv
// rtl/fetch_prefetch_q.sv - decoupled prefetching fetch stage with DEPTH-entry instruction queue
//
// Purpose:
//   Issues sequential instruction reads to imem (one outstanding at most) and
//   buffers the responses in a DEPTH-entry FIFO drained by decode via deq.
//   Branch redirects flush the queue and drop any in-flight response.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   redirect, redirect_pc  flush queue and restart fetch at redirect_pc
//   halt                stop issuing new fetches (sticky HALTED state until reset)
//   deq                 decode consumes the head entry
//   out_valid/out_instr/out_pc/out_pc_next  head entry (NOP_INSTR when empty)
//   imem_rd/imem_addr   read request, held until imem_done
//   imem_done/imem_data/imem_err  one-cycle response
//   err                 sticky memory error flag
//   fetch_stall         queue empty while a request is outstanding
//   occupancy           number of queued entries
//
// Configuration:
//   FETCH_BYPASS_EN     when defined, a response arriving at an empty queue
//                       with deq=1 is presented and consumed in the same cycle.

module fetch_prefetch_q #(
  parameter int          ADDR_W    = 16,
  parameter int          INSTR_W   = 16,
  parameter int          DEPTH     = 4,
  parameter int          PC_INC    = 2,
  parameter int          RESET_PC  = 0,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       redirect,
  input  logic [ADDR_W-1:0]          redirect_pc,
  input  logic                       halt,
  input  logic                       deq,
  output logic                       out_valid,
  output logic [INSTR_W-1:0]         out_instr,
  output logic [ADDR_W-1:0]          out_pc,
  output logic [ADDR_W-1:0]          out_pc_next,
  output logic                       imem_rd,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic                       imem_done,
  input  logic [INSTR_W-1:0]         imem_data,
  input  logic                       imem_err,
  output logic                       err,
  output logic                       fetch_stall,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]   DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0]  PC_INC_C  = ADDR_W'(PC_INC);
  localparam logic [ADDR_W-1:0]  RESET_PC_C = ADDR_W'(RESET_PC);
  localparam logic [INSTR_W-1:0] NOP_C     = INSTR_W'(NOP_INSTR);

  typedef enum logic [1:0] {
    S_ISSUE   = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2,
    S_HALTED  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic                err_q, err_d;
  logic [PTR_W-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]    count_q;

  logic [INSTR_W-1:0]  instr_mem [DEPTH];
  logic [ADDR_W-1:0]   pc_mem    [DEPTH];

  logic                resp_ok;   // accepted (non-discarded) response this cycle
  logic                byp_take;  // response consumed directly by decode
  logic                do_enq;
  logic                do_deq;

  // Fetch control FSM: next state, request outputs, PC and error updates.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    err_d      = err_q;
    imem_rd    = 1'b0;
    imem_addr  = fetch_pc_q;
    resp_ok    = 1'b0;
    unique case (state_q)
      S_ISSUE: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
          if (halt) state_d = S_HALTED;
        end else if (halt) begin
          state_d = S_HALTED;
        end else if (count_q < DEPTH_C && !rst) begin
          // rst gating keeps imem_rd low while reset is held, since the
          // async reset forces ISSUE with an empty queue.
          imem_rd    = 1'b1;
          req_addr_d = fetch_pc_q;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        imem_rd   = 1'b1;
        imem_addr = req_addr_q;
        if (redirect) begin
          fetch_pc_d = redirect_pc;
          if (imem_done) state_d = halt ? S_HALTED : S_ISSUE;
          else           state_d = S_DISCARD;
        end else if (imem_done) begin
          resp_ok    = 1'b1;
          fetch_pc_d = fetch_pc_q + PC_INC_C;
          if (imem_err) err_d = 1'b1;
          state_d = halt ? S_HALTED : S_ISSUE;
        end
      end
      S_DISCARD: begin
        imem_rd   = 1'b1;
        imem_addr = req_addr_q;
        if (redirect) fetch_pc_d = redirect_pc;
        if (imem_done) state_d = halt ? S_HALTED : S_ISSUE;
      end
      S_HALTED: begin
        if (redirect) fetch_pc_d = redirect_pc;
      end
      default: state_d = S_ISSUE;
    endcase
  end

  // Head presentation; the bypass path overrides an empty queue.
  always_comb begin
    byp_take  = 1'b0;
    out_valid = (count_q != '0);
    out_instr = out_valid ? instr_mem[rd_ptr_q] : NOP_C;
    out_pc    = pc_mem[rd_ptr_q];
`ifdef FETCH_BYPASS_EN
    if (resp_ok && count_q == '0 && deq) begin
      byp_take  = 1'b1;
      out_valid = 1'b1;
      out_instr = imem_data;
      out_pc    = req_addr_q;
    end
`endif
  end

  assign out_pc_next = out_pc + PC_INC_C;
  assign do_enq      = resp_ok & ~byp_take;
  assign do_deq      = deq & (count_q != '0) & ~redirect;
  assign err         = err_q;
  assign occupancy   = count_q;
  assign fetch_stall = (count_q == '0) & ((state_q == S_WAIT) | (state_q == S_DISCARD));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_ISSUE;
      fetch_pc_q <= RESET_PC_C;
      req_addr_q <= RESET_PC_C;
      err_q      <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      err_q      <= err_d;
      if (redirect) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (do_enq) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (do_deq) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        case ({do_enq, do_deq})
          2'b10:   count_q <= count_q + CNT_W'(1);
          2'b01:   count_q <= count_q - CNT_W'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

  // Queue storage needs no reset: entries are only read when counted valid.
  always_ff @(posedge clk) begin
    if (do_enq && !redirect) begin
      instr_mem[wr_ptr_q] <= imem_data;
      pc_mem[wr_ptr_q]    <= req_addr_q;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_q.sv
// tb/tb_fetch_prefetch_q.sv - table-driven self-checking bench for fetch_prefetch_q

module tb_fetch_prefetch_q;

  logic        clk = 1'b0;
  logic        rst, redirect, halt, deq, imem_done, imem_err;
  logic [15:0] redirect_pc, imem_data;
  logic        out_valid, imem_rd, err, fetch_stall;
  logic [15:0] out_instr, out_pc, out_pc_next, imem_addr;
  logic [2:0]  occupancy;

  int checks = 0;
  int errors = 0;

  fetch_prefetch_q dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .halt(halt), .deq(deq), .out_valid(out_valid), .out_instr(out_instr),
    .out_pc(out_pc), .out_pc_next(out_pc_next), .imem_rd(imem_rd),
    .imem_addr(imem_addr), .imem_done(imem_done), .imem_data(imem_data),
    .imem_err(imem_err), .err(err), .fetch_stall(fetch_stall),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, redir;
    logic [15:0] rpc;
    logic        halt, deq, done;
    logic [15:0] data;
    logic        ierr;
    logic        e_rd;
    logic [15:0] e_addr;
    logic        e_v;
    logic [15:0] e_pc;
    logic [2:0]  e_occ;
    logic        e_err, e_stall;
  } vec_t;

  vec_t vq[$];

  task automatic drive(input logic r, input logic rd, input logic [15:0] rp,
                       input logic h, input logic d, input logic dn,
                       input logic [15:0] dat, input logic ie);
    rst = r; redirect = rd; redirect_pc = rp; halt = h; deq = d;
    imem_done = dn; imem_data = dat; imem_err = ie;
  endtask

  // Memory image used by the stimulus: instruction = A000 | addr[11:0].
  task automatic check(input string name, input logic e_rd, input logic [15:0] e_addr,
                       input logic e_v, input logic [15:0] e_pc, input logic [2:0] e_occ,
                       input logic e_err, input logic e_stall);
    logic [15:0] e_instr, e_next;
    logic        bad;
    e_instr = e_v ? (16'hA000 | {4'h0, e_pc[11:0]}) : 16'h0800;
    e_next  = e_pc + 16'd2;
    bad = (imem_rd !== e_rd) || (out_valid !== e_v) || (out_instr !== e_instr) ||
          (occupancy !== e_occ) || (err !== e_err) || (fetch_stall !== e_stall) ||
          (e_rd && imem_addr !== e_addr) ||
          (e_v && (out_pc !== e_pc || out_pc_next !== e_next));
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s: got rd=%b addr=%h v=%b instr=%h pc=%h pcn=%h occ=%0d err=%b stall=%b; expected rd=%b addr=%h v=%b instr=%h pc=%h pcn=%h occ=%0d err=%b stall=%b",
               name, imem_rd, imem_addr, out_valid, out_instr, out_pc, out_pc_next,
               occupancy, err, fetch_stall, e_rd, e_addr, e_v, e_instr, e_pc, e_next,
               e_occ, e_err, e_stall);
    end
  endtask

  initial begin
    drive(1, 0, 16'h0, 0, 0, 0, 16'h0, 0);

    //           rst red rpc      hlt deq dn data     ie  rd addr     v pc       occ err stl
    vq.push_back('{1, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0}); // 0 reset
    vq.push_back('{0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 1, 16'h0000, 0, 16'h0000, 0, 0, 0}); // 1 issue 0
    vq.push_back('{0, 0, 16'h0000, 0, 0, 1, 16'hA000, 0, 1, 16'h0000, 0, 16'h0000, 0, 0, 1}); // 2 resp 0
    vq.push_back('{0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 1, 16'h0002, 1, 16'h0000, 1, 0, 0}); // 3
    vq.push_back('{0, 0, 16'h0000, 0, 0, 1, 16'hA002, 0, 1, 16'h0002, 1, 16'h0000, 1, 0, 0}); // 4
    vq.push_back('{0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 1, 16'h0004, 1, 16'h0000, 2, 0, 0}); // 5
    vq.push_back('{0, 0, 16'h0000, 0, 0, 1, 16'hA004, 0, 1, 16'h0004, 1, 16'h0000, 2, 0, 0}); // 6
    vq.push_back('{0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 1, 16'h0006, 1, 16'h0000, 3, 0, 0}); // 7
    vq.push_back('{0, 0, 16'h0000, 0, 0, 1, 16'hA006, 0, 1, 16'h0006, 1, 16'h0000, 3, 0, 0}); // 8
    vq.push_back('{0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 16'h0008, 1, 16'h0000, 4, 0, 0}); // 9 full
    vq.push_back('{0, 0, 16'h0000, 0, 1, 0, 16'h0000, 0, 0, 16'h0008, 1, 16'h0000, 4, 0, 0}); // 10 deq
    vq.push_back('{0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 1, 16'h0008, 1, 16'h0002, 3, 0, 0}); // 11 issue 8
    vq.push_back('{0, 0, 16'h0000, 0, 1, 0, 16'h0000, 0, 1, 16'h0008, 1, 16'h0002, 3, 0, 0}); // 12
    vq.push_back('{0, 0, 16'h0000, 0, 1, 1, 16'hA008, 0, 1, 16'h0008, 1, 16'h0004, 2, 0, 0}); // 13 enq+deq
    vq.push_back('{0, 0, 16'h0000, 0, 1, 0, 16'h0000, 0, 1, 16'h000A, 1, 16'h0006, 2, 0, 0}); // 14
    vq.push_back('{0, 0, 16'h0000, 0, 1, 0, 16'h0000, 0, 1, 16'h000A, 1, 16'h0008, 1, 0, 0}); // 15
    vq.push_back('{0, 1, 16'h0100, 0, 0, 0, 16'h0000, 0, 1, 16'h000A, 0, 16'h0000, 0, 0, 1}); // 16 redirect in WAIT
    vq.push_back('{0, 0, 16'h0000, 0, 0, 1, 16'hBEEF, 0, 1, 16'h000A, 0, 16'h0000, 0, 0, 1}); // 17 late resp dropped
    vq.push_back('{0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 1, 16'h0100, 0, 16'h0000, 0, 0, 0}); // 18 issue 0100
    vq.push_back('{0, 0, 16'h0000, 0, 0, 1, 16'hA100, 0, 1, 16'h0100, 0, 16'h0000, 0, 0, 1}); // 19
    vq.push_back('{0, 1, 16'hFFFE, 0, 0, 0, 16'h0000, 0, 0, 16'h0102, 1, 16'h0100, 1, 0, 0}); // 20 redirect in ISSUE
    vq.push_back('{0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 1, 16'hFFFE, 0, 16'h0000, 0, 0, 0}); // 21
    vq.push_back('{0, 0, 16'h0000, 0, 0, 1, 16'hAFFE, 0, 1, 16'hFFFE, 0, 16'h0000, 0, 0, 1}); // 22
    vq.push_back('{0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 1, 16'h0000, 1, 16'hFFFE, 1, 0, 0}); // 23 wrap
    vq.push_back('{0, 0, 16'h0000, 0, 0, 1, 16'hA000, 1, 1, 16'h0000, 1, 16'hFFFE, 1, 0, 0}); // 24 error resp
    vq.push_back('{0, 0, 16'h0000, 0, 1, 0, 16'h0000, 0, 1, 16'h0002, 1, 16'hFFFE, 2, 1, 0}); // 25
    vq.push_back('{0, 0, 16'h0000, 0, 0, 1, 16'hA002, 0, 1, 16'h0002, 1, 16'h0000, 1, 1, 0}); // 26 err sticky
    vq.push_back('{0, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 16'h0004, 1, 16'h0000, 2, 1, 0}); // 27 halt in ISSUE
    vq.push_back('{0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 16'h0004, 1, 16'h0000, 2, 1, 0}); // 28 halted

    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i].rst, vq[i].redir, vq[i].rpc, vq[i].halt, vq[i].deq,
            vq[i].done, vq[i].data, vq[i].ierr);
      #1;
      check($sformatf("vec%0d", i), vq[i].e_rd, vq[i].e_addr, vq[i].e_v,
            vq[i].e_pc, vq[i].e_occ, vq[i].e_err, vq[i].e_stall);
    end

    // Halt while a request is outstanding: the response still lands, then no more requests.
    @(negedge clk); drive(1, 0, 16'h0, 0, 0, 0, 16'h0, 0); #1;
    check("halt_reset", 0, 16'h0000, 0, 16'h0000, 0, 0, 0);
    @(negedge clk); drive(0, 0, 16'h0, 0, 0, 0, 16'h0, 0); #1;
    check("halt_issue", 1, 16'h0000, 0, 16'h0000, 0, 0, 0);
    @(negedge clk); drive(0, 0, 16'h0, 1, 0, 0, 16'h0, 0); #1;
    check("halt_wait_held", 1, 16'h0000, 0, 16'h0000, 0, 0, 1);
    @(negedge clk); drive(0, 0, 16'h0, 1, 0, 1, 16'hA000, 0); #1;
    check("halt_wait_resp", 1, 16'h0000, 0, 16'h0000, 0, 0, 1);
    @(negedge clk); drive(0, 0, 16'h0, 0, 0, 0, 16'h0, 0); #1;
    check("halt_enqueued", 0, 16'h0002, 1, 16'h0000, 1, 0, 0);
    @(negedge clk); #1;
    check("halt_stays", 0, 16'h0002, 1, 16'h0000, 1, 0, 0);

    // Asynchronous reset in the middle of a WAIT with a non-empty queue and err set.
    @(negedge clk); drive(1, 0, 16'h0, 0, 0, 0, 16'h0, 0); #1;
    check("ar_reset", 0, 16'h0000, 0, 16'h0000, 0, 0, 0);
    @(negedge clk); drive(0, 0, 16'h0, 0, 0, 0, 16'h0, 0); #1;
    check("ar_issue", 1, 16'h0000, 0, 16'h0000, 0, 0, 0);
    @(negedge clk); drive(0, 0, 16'h0, 0, 0, 1, 16'hA000, 1); #1;
    check("ar_err_resp", 1, 16'h0000, 0, 16'h0000, 0, 0, 1);
    @(negedge clk); drive(0, 0, 16'h0, 0, 0, 0, 16'h0, 0); #1;
    check("ar_pre", 1, 16'h0002, 1, 16'h0000, 1, 1, 0);
    @(posedge clk); #3;
    rst = 1'b1; #1;
    check("ar_async_clear", 0, 16'h0000, 0, 16'h0000, 0, 0, 0);
    @(negedge clk); #1;
    check("ar_hold", 0, 16'h0000, 0, 16'h0000, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
